// File: rtl/wall_engine.sv
// Multi-wall obstacle engine: per frame tick it erases, scrolls, redraws every wall, then scores.
// Optional build macro WALL_ENGINE_SCORE_BCD_EN makes score_out packed BCD (00..99) instead of binary.
module wall_engine #(
    parameter int          NUM_WALLS    = 2,
    parameter int          SCREEN_W     = 160,
    parameter int          SCREEN_H     = 120,
    parameter int          WALL_X_START = 100,
    parameter int          WALL_SPACING = 80,
    parameter int          WALL_WIDTH   = 10,
    parameter int          WALL_SPEED   = 4,
    parameter int          HOLE_HEIGHT  = 50,
    parameter int          HOLE_MARGIN  = 10,
    parameter int          BIRD_X       = 20,
    parameter int          BIRD_W       = 8,
    parameter int          BIRD_H       = 8,
    parameter logic [2:0]  WALL_COLOUR  = 3'b100,
    parameter logic [2:0]  BG_COLOUR    = 3'b111,
    parameter int          SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               frame_tick,
    input  logic               restart,
    input  logic [6:0]         bird_y,
    output logic [7:0]         x_out,
    output logic [6:0]         y_out,
    output logic [2:0]         colour_out,
    output logic               plot,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] score_out,
    output logic               collision
);

    localparam int XW  = 10;
    localparam int IW  = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
    localparam int DXW = (WALL_WIDTH > 1) ? $clog2(WALL_WIDTH) : 1;
    localparam logic [6:0] MAX_OFF = 7'(SCREEN_H - HOLE_HEIGHT - 2 * HOLE_MARGIN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ERASE = 3'd1,
        S_MOVE  = 3'd2,
        S_DRAW  = 3'd3,
        S_SCORE = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t             state_r, next_state_s;
    logic [XW-1:0]      wall_x_r  [NUM_WALLS];
    logic [XW-1:0]      old_x_r   [NUM_WALLS];
    logic [6:0]         hole_y_r  [NUM_WALLS];
    logic               respawn_r [NUM_WALLS];
    logic [7:0]         lfsr_r;
    logic [IW-1:0]      wall_idx_r;
    logic [6:0]         scan_y_r;
    logic [DXW-1:0]     scan_dx_r;
    logic [SCORE_W-1:0] score_r, score_next_s;
    logic               collision_r, hit_s;
    logic [7:0]         x_r;
    logic [6:0]         y_r;
    logic [2:0]         colour_r;
    logic               plot_r, busy_r, done_r;

    logic [XW-1:0]      cur_wx_s, cur_x_s;
    logic [6:0]         cur_hy_s, off_s, new_hole_s;
    logic               visible_s, in_hole_s, scan_last_s;
    logic               cross_s [NUM_WALLS];
    logic               hit_w_s [NUM_WALLS];

    function automatic logic [XW-1:0] start_x(input int idx);
        return XW'(WALL_X_START + idx * WALL_SPACING);
    endfunction

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
`ifdef WALL_ENGINE_SCORE_BCD_EN
        logic [7:0] b;
        b = 8'(s);
        if (b == 8'h99) begin
            b = b;
        end else if (b[3:0] == 4'd9) begin
            b = {b[7:4] + 4'd1, 4'd0};
        end else begin
            b = b + 8'd1;
        end
        return SCORE_W'(b);
`else
        if (s == {SCORE_W{1'b1}}) begin
            return s;
        end else begin
            return s + SCORE_W'(1);
        end
`endif
    endfunction

    // Current scan pixel: selected wall, absolute column, clipping and hole membership
    always_comb begin
        cur_wx_s = '0;
        cur_hy_s = '0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            cur_wx_s = (wall_idx_r == IW'(i)) ? wall_x_r[i] : cur_wx_s;
            cur_hy_s = (wall_idx_r == IW'(i)) ? hole_y_r[i] : cur_hy_s;
        end
        cur_x_s     = cur_wx_s + XW'(scan_dx_r);
        visible_s   = (cur_x_s < XW'(SCREEN_W));
        in_hole_s   = ({1'b0, scan_y_r} >= {1'b0, cur_hy_s}) &&
                      ({1'b0, scan_y_r} <= ({1'b0, cur_hy_s} + 8'(HOLE_HEIGHT - 1)));
        scan_last_s = (wall_idx_r == IW'(NUM_WALLS - 1)) && (scan_y_r == 7'(SCREEN_H - 1)) &&
                      (scan_dx_r == DXW'(WALL_WIDTH - 1));
    end

    // Respawn hole row from the LFSR, folded back into the legal range
    always_comb begin
        off_s = {1'b0, lfsr_r[5:0]};
        if (off_s > MAX_OFF) begin
            off_s = off_s - 7'd32;
        end else begin
            off_s = off_s;
        end
        new_hole_s = 7'(HOLE_MARGIN) + off_s;
    end

    // Score increments and bird hit detection against post-move wall positions
    always_comb begin
        score_next_s = score_r;
        hit_s        = 1'b0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            cross_s[i] = !respawn_r[i] &&
                         ((old_x_r[i] + XW'(WALL_WIDTH)) > XW'(BIRD_X)) &&
                         ((wall_x_r[i] + XW'(WALL_WIDTH)) <= XW'(BIRD_X));
            hit_w_s[i] = (wall_x_r[i] <= XW'(BIRD_X + BIRD_W - 1)) &&
                         ((wall_x_r[i] + XW'(WALL_WIDTH - 1)) >= XW'(BIRD_X)) &&
                         !(({1'b0, bird_y} >= {1'b0, hole_y_r[i]}) &&
                           (({1'b0, bird_y} + 8'(BIRD_H - 1)) <= ({1'b0, hole_y_r[i]} + 8'(HOLE_HEIGHT - 1))));
            score_next_s = cross_s[i] ? score_inc(score_next_s) : score_next_s;
            hit_s        = hit_s | hit_w_s[i];
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (restart) begin
                    next_state_s = S_IDLE;
                end else if (frame_tick && !collision_r) begin
                    next_state_s = S_ERASE;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_ERASE: next_state_s = scan_last_s ? S_MOVE : S_ERASE;
            S_MOVE:  next_state_s = S_DRAW;
            S_DRAW:  next_state_s = scan_last_s ? S_SCORE : S_DRAW;
            S_SCORE: next_state_s = S_FIN;
            S_FIN:   next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Free-running 8-bit Fibonacci LFSR, taps 8,6,5,4
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        end
    end

    // Scan counters: column inner, row middle, wall outer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wall_idx_r <= '0;
            scan_y_r   <= '0;
            scan_dx_r  <= '0;
        end else if ((state_r == S_ERASE) || (state_r == S_DRAW)) begin
            if (scan_dx_r == DXW'(WALL_WIDTH - 1)) begin
                scan_dx_r <= '0;
                if (scan_y_r == 7'(SCREEN_H - 1)) begin
                    scan_y_r   <= '0;
                    wall_idx_r <= scan_last_s ? '0 : wall_idx_r + IW'(1);
                end else begin
                    scan_y_r <= scan_y_r + 7'd1;
                end
            end else begin
                scan_dx_r <= scan_dx_r + DXW'(1);
            end
        end else begin
            wall_idx_r <= '0;
            scan_y_r   <= '0;
            scan_dx_r  <= '0;
        end
    end

    // Wall positions, holes, score and sticky collision
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_WALLS; i++) begin
                wall_x_r[i]  <= start_x(i);
                old_x_r[i]   <= start_x(i);
                hole_y_r[i]  <= 7'(HOLE_MARGIN);
                respawn_r[i] <= 1'b0;
            end
            score_r     <= '0;
            collision_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (restart) begin
                        for (int i = 0; i < NUM_WALLS; i++) begin
                            wall_x_r[i]  <= start_x(i);
                            old_x_r[i]   <= start_x(i);
                            hole_y_r[i]  <= 7'(HOLE_MARGIN);
                            respawn_r[i] <= 1'b0;
                        end
                        score_r     <= '0;
                        collision_r <= 1'b0;
                    end else begin
                        score_r <= score_r;
                    end
                end
                S_MOVE: begin
                    for (int i = 0; i < NUM_WALLS; i++) begin
                        old_x_r[i] <= wall_x_r[i];
                        if (wall_x_r[i] < XW'(WALL_SPEED)) begin
                            wall_x_r[i]  <= XW'(SCREEN_W);
                            hole_y_r[i]  <= new_hole_s;
                            respawn_r[i] <= 1'b1;
                        end else begin
                            wall_x_r[i]  <= wall_x_r[i] - XW'(WALL_SPEED);
                            respawn_r[i] <= 1'b0;
                        end
                    end
                end
                S_SCORE: begin
                    score_r     <= score_next_s;
                    collision_r <= collision_r | hit_s;
                end
                default: score_r <= score_r;
            endcase
        end
    end

    // Registered pixel stream and status outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_r      <= 8'd0;
            y_r      <= 7'd0;
            colour_r <= BG_COLOUR;
            plot_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r <= (next_state_s != S_IDLE);
            done_r <= (state_r == S_FIN);
            case (state_r)
                S_ERASE: begin
                    x_r      <= cur_x_s[7:0];
                    y_r      <= scan_y_r;
                    colour_r <= BG_COLOUR;
                    plot_r   <= visible_s;
                end
                S_DRAW: begin
                    x_r      <= cur_x_s[7:0];
                    y_r      <= scan_y_r;
                    colour_r <= WALL_COLOUR;
                    plot_r   <= visible_s && !in_hole_s;
                end
                default: plot_r <= 1'b0;
            endcase
        end
    end

    assign x_out      = x_r;
    assign y_out      = y_r;
    assign colour_out = colour_r;
    assign plot       = plot_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign score_out  = score_r;
    assign collision  = collision_r;

endmodule

// File: tb/tb_wall_engine.sv
// Directed bench for wall_engine: walls start at x=18/22 so scoring, respawn and collision happen
// within a few updates; a 1-bit score makes saturation reachable.
module tb_wall_engine;

    localparam int         SW   = 1;
    localparam int         LAT  = 2 * 2 * 10 * 120 + 3;
    localparam logic [2:0] WALL = 3'b100;
    localparam logic [2:0] BG   = 3'b111;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          frame_tick = 1'b0;
    logic          restart = 1'b0;
    logic [6:0]    bird_y = 7'd0;
    logic [7:0]    x_out;
    logic [6:0]    y_out;
    logic [2:0]    colour_out;
    logic          plot, busy, done, collision;
    logic [SW-1:0] score_out;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    wall_engine #(.WALL_X_START(18), .WALL_SPACING(4), .SCORE_W(SW)) dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .restart(restart), .bird_y(bird_y),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot(plot), .busy(busy),
        .done(done), .score_out(score_out), .collision(collision)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, 32'(x_out), 32'd0);
        check({tag, "_y"}, 32'(y_out), 32'd0);
        check({tag, "_colour"}, 32'(colour_out), 32'(BG));
        check({tag, "_plot"}, 32'(plot), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_score"}, 32'(score_out), 32'd0);
        check({tag, "_coll"}, 32'(collision), 32'd0);
    endtask

    // One update: returns latency to done, plotted pixels, first plotted pixel, first draw pixel,
    // and the first missing draw row in column gap_col.
    task automatic run_tick(input logic [6:0] b, input int hold, input int gap_col,
                            output int lat, output int plots, output int first_x,
                            output int draw_x, output int draw_y, output int gap,
                            output logic acc_busy);
        int prev;
        @(negedge clk);
        bird_y = b;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        acc_busy = busy;
        lat = 0; plots = 0; first_x = -1; draw_x = -1; draw_y = -1; gap = -1; prev = -1;
        while (1) begin
            if (lat >= hold) frame_tick = 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (plot) begin
                plots++;
                if (first_x < 0) first_x = int'(x_out);
                if (colour_out == WALL && draw_x < 0) begin
                    draw_x = int'(x_out);
                    draw_y = int'(y_out);
                end
                if (colour_out == WALL && int'(x_out) == gap_col) begin
                    if (gap < 0 && int'(y_out) != prev + 1) gap = prev + 1;
                    prev = int'(y_out);
                end
            end
            if (done || lat > 6000) break;
        end
        frame_tick = 1'b0;
    endtask

    task automatic idle_after(input string tag);
        int busy_seen;
        busy_seen = 0;
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (busy) busy_seen++;
            @(posedge clk);
            #1;
        end
        check({tag, "_stay_idle"}, 32'(busy_seen), 32'd0);
    endtask

    initial begin
        int lat, plots, fx, dx, dy, gap, busy_seen;
        logic ab;

        #2 resetn = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Tick 1, held high 3 extra cycles: walls 18/22 -> 14/18, bird inside hole
        run_tick(7'd20, 3, -1, lat, plots, fx, dx, dy, gap, ab);
        check("t1_busy", 32'(ab), 32'd1);
        check("t1_latency", 32'(lat), 32'(LAT));
        check("t1_plots", 32'(plots), 32'd3800);
        check("t1_first_erase_x", 32'(fx), 32'd18);
        check("t1_first_draw_x", 32'(dx), 32'd14);
        check("t1_first_draw_y", 32'(dy), 32'd0);
        check("t1_score", 32'(score_out), 32'd0);
        check("t1_coll", 32'(collision), 32'd0);
        check("t1_busy_at_done", 32'(busy), 32'd0);
        idle_after("t1");

        // Tick 2: wall 0 right edge 24 -> 20 reaches bird column, scores
        run_tick(7'd20, 0, -1, lat, plots, fx, dx, dy, gap, ab);
        check("t2_first_draw_x", 32'(dx), 32'd10);
        check("t2_score", 32'(score_out), 32'd1);
        check("t2_coll", 32'(collision), 32'd0);

        // Tick 3: wall 1 passes, score saturated at 1
        run_tick(7'd20, 0, -1, lat, plots, fx, dx, dy, gap, ab);
        check("t3_score_sat", 32'(score_out), 32'd1);
        check("t3_coll", 32'(collision), 32'd0);

        // Tick 4: walls 6/10 -> 2/6
        run_tick(7'd20, 0, -1, lat, plots, fx, dx, dy, gap, ab);
        check("t4_plots", 32'(plots), 32'd3800);

        // Tick 5: wall 0 at x=2 respawns at 160 and draws nothing
        run_tick(7'd20, 0, -1, lat, plots, fx, dx, dy, gap, ab);
        check("t5_plots", 32'(plots), 32'd3100);
        check("t5_first_draw_x", 32'(dx), 32'd2);
        check("t5_score", 32'(score_out), 32'd1);

        // Tick 6: wall 0 at 156 shows 4 columns; wall 1 respawns
        run_tick(7'd20, 0, 156, lat, plots, fx, dx, dy, gap, ab);
        check("t6_plots", 32'(plots), 32'd1480);
        check("t6_first_draw_x", 32'(dx), 32'd156);
        check("t6_hole_in_range", 32'((gap >= 10) && (gap <= 60)), 32'd1);

        // Restart reloads positions and score
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_score", 32'(score_out), 32'd0);

        // Tick 7: bird above hole with wall 0 over it -> collision
        run_tick(7'd0, 0, -1, lat, plots, fx, dx, dy, gap, ab);
        check("t7_first_erase_x", 32'(fx), 32'd18);
        check("t7_coll", 32'(collision), 32'd1);

        // Ticks ignored while collided
        @(negedge clk);
        frame_tick = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_seen++;
        end
        frame_tick = 1'b0;
        check("coll_tick_ignored", 32'(busy_seen), 32'd0);

        // Restart with tick: restart wins, collision cleared; repeat with collision already clear
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            restart = 1'b1;
            frame_tick = 1'b1;
            @(negedge clk);
            restart = 1'b0;
            frame_tick = 1'b0;
            busy_seen = 0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1;
                if (busy) busy_seen++;
            end
            check("restart_prio_busy", 32'(busy_seen), 32'd0);
            check("restart_coll", 32'(collision), 32'd0);
        end

        // Bird rows 52..59 exactly inside hole 10..59: no hit
        run_tick(7'd52, 0, -1, lat, plots, fx, dx, dy, gap, ab);
        check("edge52_coll", 32'(collision), 32'd0);
        // Bird rows 53..60 poke out of hole under wall 1; wall 0 scores
        run_tick(7'd53, 0, -1, lat, plots, fx, dx, dy, gap, ab);
        check("edge53_coll", 32'(collision), 32'd1);
        check("edge53_score", 32'(score_out), 32'd1);

        // Async reset in the middle of DRAW
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        repeat (3000) @(posedge clk);
        #1;
        check("mid_draw_busy", 32'(busy), 32'd1);
        #1 resetn = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        resetn = 1'b1;

        run_tick(7'd20, 0, -1, lat, plots, fx, dx, dy, gap, ab);
        check("post_reset_first_x", 32'(fx), 32'd18);
        check("post_reset_latency", 32'(lat), 32'(LAT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
